// File: rtl/rom_loader.sv
// Byte-stream loader for the instruction ROM write port; holds the core in reset while loading.
// Optional trailing checksum byte is enabled by defining ROM_LOADER_CSUM_EN.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_NUM   = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        wen,
  output logic [31:0] w_addr,
  output logic [31:0] w_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam int IW = $clog2(MEM_NUM + 1);

`ifdef ROM_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, CSUM, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, DONE
  } state_t;
`endif

  state_t          state;
  logic [1:0]      bcnt;
  logic [31:0]     len;
  logic [31:0]     sh;
  logic [IW-1:0]   widx;
`ifdef ROM_LOADER_CSUM_EN
  logic [7:0]      sum;
`endif

  logic        acc;
  logic [31:0] len_nx;
  logic [31:0] sh_nx;
  logic        last;

  assign acc    = s_valid && s_ready;
  // Shifting in from the top leaves the first byte in [7:0].
  assign len_nx = {s_data, len[31:8]};
  assign sh_nx  = {s_data, sh[31:8]};
  assign last   = (32'(widx) + 32'd1) == len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bcnt     <= '0;
      len      <= '0;
      sh       <= '0;
      widx     <= '0;
`ifdef ROM_LOADER_CSUM_EN
      sum      <= '0;
`endif
      s_ready  <= 1'b0;
      wen      <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LEN;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            s_ready  <= 1'b1;
            err      <= 1'b0;
            bcnt     <= '0;
            widx     <= '0;
            len      <= '0;
`ifdef ROM_LOADER_CSUM_EN
            sum      <= '0;
`endif
          end
        end
        LEN: begin
          if (acc) begin
            len  <= len_nx;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (len_nx > 32'(MEM_NUM)) begin
                err      <= 1'b1;
                state    <= DONE;
                s_ready  <= 1'b0;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
              end else if (len_nx == 32'd0) begin
`ifdef ROM_LOADER_CSUM_EN
                state    <= CSUM;
`else
                state    <= DONE;
                s_ready  <= 1'b0;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
`endif
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (acc) begin
            sh   <= sh_nx;
            bcnt <= bcnt + 2'd1;
`ifdef ROM_LOADER_CSUM_EN
            sum  <= sum + s_data;
`endif
            if (bcnt == 2'd3) begin
              state   <= WRITE;
              s_ready <= 1'b0;
              wen     <= 1'b1;
              w_addr  <= BASE_ADDR + (32'(widx) << 2);
              w_data  <= sh_nx;
            end
          end
        end
        WRITE: begin
          widx <= widx + IW'(1);
          if (last) begin
`ifdef ROM_LOADER_CSUM_EN
            state    <= CSUM;
            s_ready  <= 1'b1;
`else
            state    <= DONE;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            state   <= DATA;
            s_ready <= 1'b1;
          end
        end
`ifdef ROM_LOADER_CSUM_EN
        CSUM: begin
          if (acc) begin
            if (s_data != sum)
              err <= 1'b1;
            state    <= DONE;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized self-checking bench for rom_loader against a word-list reference model.
// Covers header parsing, stalls, overflow, empty load, mid-load reset and checksum.
module tb_rom_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MEMN = 4096;
`ifdef ROM_LOADER_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        wen;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  rom_loader #(
    .BASE_ADDR(BASE),
    .MEM_NUM  (MEMN)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .wen     (wen),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] wq[$];
  int          ndone = 0;
  logic        err_done = 1'b0;
  int          hold_bad = 0;
  logic [7:0]  fixed[$];

  always @(negedge clk) begin
    if (wen) wq.push_back({w_addr, w_data});
    if (done) begin
      ndone++;
      err_done = err;
    end
    if (cpu_hold !== busy) hold_bad++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_tmo", 64'd0, 64'd1);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] len, input int maxgap,
                          input bit bad_cs, input bit mid_start,
                          input string tag);
    logic [7:0]  pl[$];
    logic [63:0] exp[$];
    logic [7:0]  sum;
    logic [7:0]  lb;
    bit          ovf;
    bit          exp_err;
    int          nw;
    int          d0;
    int          n;
    sum = 8'h00;
    ovf = len > 32'(MEMN);
    nw  = ovf ? 0 : int'(len);
    for (int i = 0; i < nw * 4; i++) begin
      if (fixed.size() > i) pl.push_back(fixed[i]);
      else pl.push_back(8'($urandom));
      sum = sum + pl[i];
    end
    for (int w = 0; w < nw; w++)
      exp.push_back({BASE + 32'(4 * w), pl[4*w+3], pl[4*w+2],
                     pl[4*w+1], pl[4*w]});
    exp_err = ovf || (CS && bad_cs);
    wq.delete();
    d0 = ndone;
    hold_bad = 0;
    pulse_start();
    check({tag, "_busy_on"}, {62'd0, busy, cpu_hold}, 64'd3);
    check({tag, "_err_clr"}, {63'd0, err}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      lb = len[8*i +: 8];
      send_byte(lb);
      if (maxgap > 0) gap($urandom_range(0, maxgap));
    end
    for (int i = 0; i < nw * 4; i++) begin
      send_byte(pl[i]);
      if (maxgap > 0) gap($urandom_range(0, maxgap));
      if (mid_start && i == 2) pulse_start();
    end
    if (CS && !ovf) send_byte(bad_cs ? sum + 8'd1 : sum);
    gap(1);
    n = 0;
    while (ndone == d0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    gap(2);
    check({tag, "_ndone"}, 64'(ndone - d0), 64'd1);
    check({tag, "_err"}, {63'd0, err_done}, {63'd0, exp_err});
    check({tag, "_busy_off"}, {62'd0, busy, cpu_hold}, 64'd0);
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_nwen"}, 64'(wq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++)
      check({tag, "_word"}, wq[i], exp[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctl", {58'd0, s_ready, wen, busy, done, err, cpu_hold}, 64'd0);
    check("rst_wr", {w_addr, w_data}, 64'd0);
    rstn = 1'b1;
    gap(2);

    fixed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'd2, 0, 1'b0, 1'b0, "t1");
    check("t1_w0", wq[0], {32'h100, 32'h44332211});
    check("t1_w1", wq[1], {32'h104, 32'h88776655});
    run_load(32'd2, 0, 1'b0, 1'b1, "t2mid");
    fixed.delete();

    run_load(32'h1001, 0, 1'b0, 1'b0, "ovf");
    run_load(32'hFFFF_FFFF, 2, 1'b0, 1'b0, "ovfmax");
    fixed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(32'd1, 0, 1'b0, 1'b0, "after_ovf");
    check("after_ovf_w", wq[0], {32'h100, 32'hDDCCBBAA});
    fixed.delete();

    run_load(32'd0, 1, 1'b0, 1'b0, "len0");

    // Reset after 6 payload bytes of a 2-word load.
    wq.delete();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i));
    gap(1);
    rstn = 1'b0;
    #1;
    check("mrst_ctl", {58'd0, s_ready, wen, busy, done, err, cpu_hold}, 64'd0);
    check("mrst_wr", {w_addr, w_data}, 64'd0);
    check("mrst_nwen", 64'(wq.size()), 64'd1);
    check("mrst_w0", wq[0], {32'h100, 32'hC3C2C1C0});
    gap(1);
    rstn = 1'b1;
    gap(1);
    run_load(32'd2, 1, 1'b0, 1'b0, "restart");

    if (CS) begin
      fixed = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_load(32'd1, 0, 1'b0, 1'b0, "cs_ok");
      check("cs_ok_w", wq[0], {32'h100, 32'h04030201});
      run_load(32'd1, 0, 1'b1, 1'b0, "cs_bad");
      check("cs_bad_w", wq[0], {32'h100, 32'h04030201});
      fixed.delete();
      run_load(32'd0, 0, 1'b1, 1'b0, "cs0_bad");
    end

    repeat (12)
      run_load(32'($urandom_range(0, 8)), 3, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), "rnd");

    run_load(32'(MEMN), 0, 1'b0, 1'b0, "full");
    run_load(32'(MEMN + 1), 0, 1'b0, 1'b0, "ovf1");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
Writer-side front end for the instruction ROM's write port. It takes a byte stream (valid/ready), parses a length header, assembles little-endian 32-bit words and issues single-cycle word writes (wen/w_addr/w_data) with byte addresses, so the ROM's addr[31:2] indexing lands on consecutive words. While loading it holds the CPU in reset through cpu_hold.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written (word-aligned).
MEM_NUM, 4096, maximum number of words accepted; must match the ROM depth.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load; ignored while busy=1
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_ready  output  1  byte accepted when s_valid && s_ready
wen  output  1  ROM write enable, one-cycle pulse per word
w_addr  output  32  ROM write byte address
w_data  output  32  ROM write data
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of load (success or error)
err  output  1  sticky error flag, cleared by the next accepted start
cpu_hold  output  1  equals busy; keeps the core in reset during load

Behaviour:
- Clock is clk, reset is rstn: one clock, asynchronous assert, active-low. At reset, all outputs are 0, state is IDLE, and all counters are 0.
- States: IDLE, LEN, DATA, WRITE, CSUM (macro only), DONE.
- IDLE: s_ready=0. start=1 moves to LEN, sets busy, clears err, and clears the byte, word and checksum counters.
- LEN: s_ready=1. Four accepted bytes form len[31:0], little-endian, first byte in [7:0].
  - After the 4th byte:
    - len > MEM_NUM: set err and go to DONE. No wen is issued.
    - len == 0: go to CSUM if the macro is defined, otherwise DONE.
    - Otherwise: go to DATA.
- DATA: s_ready=1.
  - Byte k of the current word goes to w_data[8k+7:8k].
  - After the 4th byte, go to WRITE.
  - Idle s_valid cycles stall the state with no side effects.
- WRITE: s_ready=0 and wen=1 for exactly one cycle.
  - w_addr = BASE_ADDR + 4*word_idx. w_data is the assembled word.
  - word_idx increments.
  - If word_idx+1 == len: go to CSUM (macro) or DONE. Otherwise go back to DATA.
- Latency: wen is asserted in the cycle after the handshake of the 4th byte of a word. Minimum 5 cycles per word.
- w_addr and w_data are held between writes. They are only meaningful while wen=1.
- DONE: done=1 and busy/cpu_hold drop in the same cycle, then return to IDLE. A start arriving in DONE is ignored.
- start while busy: no effect.
- Address never wraps because len ≤ MEM_NUM. word_idx is wide enough for MEM_NUM.
- rstn asserted mid-load: immediate return to IDLE, cpu_hold=0, partial word discarded. Words already written stay in the ROM.

Optional Feature:
ROM_LOADER_CSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every payload byte. Header bytes are excluded.
  - CSUM state: s_ready=1, and one byte is accepted.
  - If that byte != sum, set err. Either way, go to DONE.
  - For len==0 the expected checksum is 0x00.
- Not defined:
  - There is no CSUM state and no sum register.
  - err is set only by length overflow.

Test Plan:
- Reset, then start; stream len=02 00 00 00 and bytes 11 22 33 44 55 66 77 88 -> wen at w_addr=0x0 with w_data=0x44332211, then w_addr=0x4 with w_data=0x88776655. Then done pulse, err=0, cpu_hold 1→0.
- Same load with s_valid deasserted for 3 cycles between bytes and BASE_ADDR=0x100 -> identical data, addresses 0x100/0x104, exactly 2 wen pulses, none during gaps.
- len=0x1001 with MEM_NUM=4096 -> no wen, done pulse with err=1. A following start with len=1 and data AA BB CC DD -> err clears, w_data=0xDDCCBBAA.
- len=0 -> done after header (plus one checksum byte 0x00 with the macro), no wen, err=0. A second start pulse during the load is ignored: word count and addresses are unchanged.
- rstn low after 6 payload bytes of a 2-word load -> outputs 0 immediately, exactly one wen was seen. A restarted full load completes normally.
- With ROM_LOADER_CSUM_EN, data 01 02 03 04: checksum byte 0x0A -> err=0; checksum byte 0x0B -> err=1. In both cases the word 0x04030201 is still written.
